mmio_host_driver: RTL and testbench

Hardware-side MMIO initiator that programs and runs the ring-oscillator capture AFU's register map without software. On `start` it writes the DMA and capture configuration registers and reads each one back to check it. It then pulses `go` and polls the done register until completion or timeout. It is used for self-test and bench bring-up, driving the same MMIO write/read ports the AFU register map responds to.

---
 rtl/mmio_host_driver.sv | 247 ++++++++++++++++++++++++
 tb/tb_mmio_host_driver.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_driver.sv
// MMIO initiator for the ring-oscillator capture AFU. It writes the DMA and capture
// configuration, checks each register by readback, starts the run and polls for done.
module mmio_host_driver #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int POLL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_rd_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [SIZE_WIDTH-1:0] cfg_num_samples,
    input  logic [SIZE_WIDTH-1:0] cfg_collect_cycles,
    input  logic [POLL_WIDTH-1:0] poll_interval,
    input  logic [POLL_WIDTH-1:0] max_polls,
    output logic                  mmio_wr_en,
    output logic [15:0]           mmio_wr_addr,
    output logic [63:0]           mmio_wr_data,
    output logic                  mmio_rd_en,
    output logic [15:0]           mmio_rd_addr,
    input  logic [63:0]           mmio_rd_data,
    output logic                  busy,
    output logic                  complete,
    output logic                  err_mismatch,
    output logic                  err_timeout,
    output logic [POLL_WIDTH-1:0] poll_count
);

    localparam int          LAT_W     = $clog2(RD_LATENCY + 1);
    localparam logic [15:0] ADDR_GO   = 16'h0050;
    localparam logic [15:0] ADDR_CFG0 = 16'h0052;
    localparam logic [15:0] ADDR_DONE = 16'h0060;

    // Each state names what is on the bus during that cycle.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_CFG    = 4'd1,
        S_RB_REQ    = 4'd2,
        S_RB_WAIT   = 4'd3,
        S_WR_GO     = 4'd4,
        S_POLL_REQ  = 4'd5,
        S_POLL_WAIT = 4'd6,
        S_POLL_GAP  = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cfg_rd_addr;
    logic [ADDR_WIDTH-1:0] r_cfg_wr_addr;
    logic [SIZE_WIDTH-1:0] r_cfg_num_samples;
    logic [SIZE_WIDTH-1:0] r_cfg_collect_cycles;
    logic [POLL_WIDTH-1:0] r_poll_interval;
    logic [POLL_WIDTH-1:0] r_max_polls;
    logic [POLL_WIDTH-1:0] r_gap;
    logic [2:0]            r_idx;
    logic [LAT_W-1:0]      r_lat;

    logic [63:0]           w_rb_expect;
    logic                  w_rb_match;
    logic                  w_lat_done;
    logic                  w_poll_limit;
    logic [POLL_WIDTH-1:0] w_poll_count_inc;

    function automatic logic [15:0] cfg_addr(input logic [1:0] idx);
        return ADDR_CFG0 + {13'd0, idx, 1'b0};
    endfunction

    function automatic logic [63:0] cfg_word(
        input logic [1:0]            idx,
        input logic [ADDR_WIDTH-1:0] rd_addr,
        input logic [ADDR_WIDTH-1:0] wr_addr,
        input logic [SIZE_WIDTH-1:0] num_samples,
        input logic [SIZE_WIDTH-1:0] collect_cycles
    );
        case (idx)
            2'd0:    return 64'(rd_addr);
            2'd1:    return 64'(wr_addr);
            2'd2:    return 64'(num_samples);
            default: return 64'(collect_cycles);
        endcase
    endfunction

    assign w_rb_expect      = cfg_word(r_idx[1:0], r_cfg_rd_addr, r_cfg_wr_addr,
                                       r_cfg_num_samples, r_cfg_collect_cycles);
    assign w_rb_match       = (mmio_rd_data == w_rb_expect);
    assign w_lat_done       = (r_lat == LAT_W'(RD_LATENCY));
    assign w_poll_limit     = (r_max_polls != {POLL_WIDTH{1'b0}}) && (poll_count == r_max_polls);
    assign w_poll_count_inc = (poll_count == {POLL_WIDTH{1'b1}}) ? poll_count
                            : poll_count + {{(POLL_WIDTH-1){1'b0}}, 1'b1};

    // Sequencer: strobes default low every cycle and are raised only for the cycle they apply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state              <= S_IDLE;
            r_cfg_rd_addr        <= {ADDR_WIDTH{1'b0}};
            r_cfg_wr_addr        <= {ADDR_WIDTH{1'b0}};
            r_cfg_num_samples    <= {SIZE_WIDTH{1'b0}};
            r_cfg_collect_cycles <= {SIZE_WIDTH{1'b0}};
            r_poll_interval      <= {POLL_WIDTH{1'b0}};
            r_max_polls          <= {POLL_WIDTH{1'b0}};
            r_gap                <= {POLL_WIDTH{1'b0}};
            r_idx                <= 3'd0;
            r_lat                <= {LAT_W{1'b0}};
            mmio_wr_en           <= 1'b0;
            mmio_wr_addr         <= 16'd0;
            mmio_wr_data         <= 64'd0;
            mmio_rd_en           <= 1'b0;
            mmio_rd_addr         <= 16'd0;
            busy                 <= 1'b0;
            complete             <= 1'b0;
            err_mismatch         <= 1'b0;
            err_timeout          <= 1'b0;
            poll_count           <= {POLL_WIDTH{1'b0}};
        end else begin
            mmio_wr_en   <= 1'b0;
            mmio_wr_addr <= 16'd0;
            mmio_wr_data <= 64'd0;
            mmio_rd_en   <= 1'b0;
            mmio_rd_addr <= 16'd0;
            complete     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cfg_rd_addr        <= cfg_rd_addr;
                        r_cfg_wr_addr        <= cfg_wr_addr;
                        r_cfg_num_samples    <= cfg_num_samples;
                        r_cfg_collect_cycles <= cfg_collect_cycles;
                        r_poll_interval      <= poll_interval;
                        r_max_polls          <= max_polls;
                        err_mismatch         <= 1'b0;
                        err_timeout          <= 1'b0;
                        poll_count           <= {POLL_WIDTH{1'b0}};
                        busy                 <= 1'b1;
                        mmio_wr_en           <= 1'b1;
                        mmio_wr_addr         <= ADDR_CFG0;
                        mmio_wr_data         <= 64'(cfg_rd_addr);
                        r_idx                <= 3'd1;
                        r_state              <= S_WR_CFG;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                S_WR_CFG: begin
                    if (r_idx[2]) begin
                        mmio_rd_en   <= 1'b1;
                        mmio_rd_addr <= cfg_addr(2'd0);
                        r_idx        <= 3'd0;
                        r_state      <= S_RB_REQ;
                    end else begin
                        mmio_wr_en   <= 1'b1;
                        mmio_wr_addr <= cfg_addr(r_idx[1:0]);
                        mmio_wr_data <= cfg_word(r_idx[1:0], r_cfg_rd_addr, r_cfg_wr_addr,
                                                 r_cfg_num_samples, r_cfg_collect_cycles);
                        r_idx        <= r_idx + 3'd1;
                    end
                end

                S_RB_REQ: begin
                    r_lat   <= {{(LAT_W-1){1'b0}}, 1'b1};
                    r_state <= S_RB_WAIT;
                end

                S_RB_WAIT: begin
                    if (!w_lat_done) begin
                        r_lat <= r_lat + LAT_W'(1'b1);
                    end else if (!w_rb_match) begin
                        err_mismatch <= 1'b1;
                        complete     <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= S_FINISH;
                    end else if (r_idx == 3'd3) begin
                        mmio_wr_en   <= 1'b1;
                        mmio_wr_addr <= ADDR_GO;
                        mmio_wr_data <= 64'd1;
                        r_state      <= S_WR_GO;
                    end else begin
                        mmio_rd_en   <= 1'b1;
                        mmio_rd_addr <= cfg_addr(r_idx[1:0] + 2'd1);
                        r_idx        <= r_idx + 3'd1;
                        r_state      <= S_RB_REQ;
                    end
                end

                S_WR_GO: begin
                    mmio_rd_en   <= 1'b1;
                    mmio_rd_addr <= ADDR_DONE;
                    poll_count   <= w_poll_count_inc;
                    r_state      <= S_POLL_REQ;
                end

                S_POLL_REQ: begin
                    r_lat   <= {{(LAT_W-1){1'b0}}, 1'b1};
                    r_state <= S_POLL_WAIT;
                end

                S_POLL_WAIT: begin
                    if (!w_lat_done) begin
                        r_lat <= r_lat + LAT_W'(1'b1);
                    end else if (mmio_rd_data[0]) begin
                        complete <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= S_FINISH;
                    end else if (w_poll_limit) begin
                        err_timeout <= 1'b1;
                        complete    <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_FINISH;
                    end else if (r_poll_interval == {POLL_WIDTH{1'b0}}) begin
                        mmio_rd_en   <= 1'b1;
                        mmio_rd_addr <= ADDR_DONE;
                        poll_count   <= w_poll_count_inc;
                        r_state      <= S_POLL_REQ;
                    end else begin
                        r_gap   <= {{(POLL_WIDTH-1){1'b0}}, 1'b1};
                        r_state <= S_POLL_GAP;
                    end
                end

                S_POLL_GAP: begin
                    if (r_gap == r_poll_interval) begin
                        mmio_rd_en   <= 1'b1;
                        mmio_rd_addr <= ADDR_DONE;
                        poll_count   <= w_poll_count_inc;
                        r_state      <= S_POLL_REQ;
                    end else begin
                        r_gap <= r_gap + {{(POLL_WIDTH-1){1'b0}}, 1'b1};
                    end
                end

                S_FINISH: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_host_driver.sv
// Directed bench for mmio_host_driver: one instance at read latency 1 and one at latency 3,
// each answered by a small register-file responder and observed by a bus logger.
module tb_mmio_host_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] cfg_rd_addr, cfg_wr_addr;
    logic [31:0] cfg_num_samples, cfg_collect_cycles;
    logic [15:0] poll_interval, max_polls;

    logic        d1_wr_en, d1_rd_en, d1_busy, d1_complete, d1_err_mm, d1_err_to;
    logic [15:0] d1_wr_addr, d1_rd_addr, d1_poll_count;
    logic [63:0] d1_wr_data, d1_rd_data;
    logic        d3_wr_en, d3_rd_en, d3_busy, d3_complete, d3_err_mm, d3_err_to;
    logic [15:0] d3_wr_addr, d3_rd_addr, d3_poll_count;
    logic [63:0] d3_wr_data, d3_rd_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_at = 0;
    bit corrupt = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmio_host_driver #(.ADDR_WIDTH(64), .SIZE_WIDTH(32), .RD_LATENCY(1), .POLL_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .cfg_rd_addr(cfg_rd_addr), .cfg_wr_addr(cfg_wr_addr),
        .cfg_num_samples(cfg_num_samples), .cfg_collect_cycles(cfg_collect_cycles),
        .poll_interval(poll_interval), .max_polls(max_polls),
        .mmio_wr_en(d1_wr_en), .mmio_wr_addr(d1_wr_addr), .mmio_wr_data(d1_wr_data),
        .mmio_rd_en(d1_rd_en), .mmio_rd_addr(d1_rd_addr), .mmio_rd_data(d1_rd_data),
        .busy(d1_busy), .complete(d1_complete), .err_mismatch(d1_err_mm),
        .err_timeout(d1_err_to), .poll_count(d1_poll_count)
    );

    mmio_host_driver #(.ADDR_WIDTH(64), .SIZE_WIDTH(32), .RD_LATENCY(3), .POLL_WIDTH(16)) dut3 (
        .clk(clk), .rst(rst), .start(start),
        .cfg_rd_addr(cfg_rd_addr), .cfg_wr_addr(cfg_wr_addr),
        .cfg_num_samples(cfg_num_samples), .cfg_collect_cycles(cfg_collect_cycles),
        .poll_interval(poll_interval), .max_polls(max_polls),
        .mmio_wr_en(d3_wr_en), .mmio_wr_addr(d3_wr_addr), .mmio_wr_data(d3_wr_data),
        .mmio_rd_en(d3_rd_en), .mmio_rd_addr(d3_rd_addr), .mmio_rd_data(d3_rd_data),
        .busy(d3_busy), .complete(d3_complete), .err_mismatch(d3_err_mm),
        .err_timeout(d3_err_to), .poll_count(d3_poll_count)
    );

    // Responders: register file, optional corruption of 0x56, done after done_at polls.
    logic [63:0] mem1 [0:127];
    logic [63:0] mem3 [0:127];
    logic [63:0] p3a = 64'd0, p3b = 64'd0;
    int polls1 = 0, polls3 = 0;

    always @(posedge clk) begin
        if (start && !d1_busy) polls1 <= 0;
        d1_rd_data <= 64'd0;
        if (d1_wr_en) mem1[d1_wr_addr[6:0]] <= d1_wr_data;
        if (d1_rd_en) begin
            if (d1_rd_addr == 16'h0060) begin
                polls1 <= polls1 + 1;
                d1_rd_data <= (done_at != 0 && polls1 + 1 >= done_at) ? 64'h1 : 64'hFFFF_FFFF_FFFF_FFFE;
            end else begin
                d1_rd_data <= mem1[d1_rd_addr[6:0]] ^ ((corrupt && d1_rd_addr == 16'h0056) ? 64'h100 : 64'h0);
            end
        end
    end

    always @(posedge clk) begin
        if (start && !d3_busy) polls3 <= 0;
        p3a <= 64'd0;
        p3b <= p3a;
        d3_rd_data <= p3b;
        if (d3_wr_en) mem3[d3_wr_addr[6:0]] <= d3_wr_data;
        if (d3_rd_en) begin
            if (d3_rd_addr == 16'h0060) begin
                polls3 <= polls3 + 1;
                p3a <= (done_at != 0 && polls3 + 1 >= done_at) ? 64'h1 : 64'hFFFF_FFFF_FFFF_FFFE;
            end else begin
                p3a <= mem3[d3_rd_addr[6:0]] ^ ((corrupt && d3_rd_addr == 16'h0056) ? 64'h100 : 64'h0);
            end
        end
    end

    // Bus loggers, sampled on the falling edge.
    logic [15:0] w1_addr [0:255]; logic [63:0] w1_data [0:255]; int w1_cyc [0:255]; int w1_n = 0;
    logic [15:0] r1_addr [0:255]; int r1_cyc [0:255]; int r1_n = 0;
    int c1_cyc [0:63]; bit c1_busy [0:63]; bit c1_pbusy [0:63]; int c1_n = 0;
    logic [15:0] w3_addr [0:255]; int w3_cyc [0:255]; int w3_n = 0;
    logic [15:0] r3_addr [0:255]; int r3_cyc [0:255]; int r3_n = 0;
    int c3_cyc [0:63]; int c3_n = 0;
    int stray1 = 0, stray3 = 0, ovl1 = 0, ovl3 = 0;
    bit pb1 = 1'b0;

    always @(negedge clk) begin
        if (d1_wr_en) begin
            w1_addr[w1_n] = d1_wr_addr; w1_data[w1_n] = d1_wr_data; w1_cyc[w1_n] = cyc; w1_n++;
        end else if (d1_wr_addr !== 16'd0 || d1_wr_data !== 64'd0) stray1++;
        if (d1_rd_en) begin
            r1_addr[r1_n] = d1_rd_addr; r1_cyc[r1_n] = cyc; r1_n++;
        end else if (d1_rd_addr !== 16'd0) stray1++;
        if (d1_wr_en && d1_rd_en) ovl1++;
        if (d1_complete) begin
            c1_cyc[c1_n] = cyc; c1_busy[c1_n] = d1_busy; c1_pbusy[c1_n] = pb1; c1_n++;
        end
        pb1 = d1_busy;
        if (d3_wr_en) begin
            w3_addr[w3_n] = d3_wr_addr; w3_cyc[w3_n] = cyc; w3_n++;
        end else if (d3_wr_addr !== 16'd0 || d3_wr_data !== 64'd0) stray3++;
        if (d3_rd_en) begin
            r3_addr[r3_n] = d3_rd_addr; r3_cyc[r3_n] = cyc; r3_n++;
        end else if (d3_rd_addr !== 16'd0) stray3++;
        if (d3_wr_en && d3_rd_en) ovl3++;
        if (d3_complete) begin
            c3_cyc[c3_n] = cyc; c3_n++;
        end
    end

    int s0, wb1, rb1, cb1, wb3, rb3, cb3;
    logic [63:0] exp_data [0:4];
    bit ok;

    task automatic set_cfg_a();
        cfg_rd_addr        = 64'h1122_3344_5566_7788;
        cfg_wr_addr        = 64'h99AA_BBCC_DDEE_FF00;
        cfg_num_samples    = 32'h0000_1000;
        cfg_collect_cycles = 32'hDEAD_BEEF;
        exp_data[0] = 64'h1122_3344_5566_7788;
        exp_data[1] = 64'h99AA_BBCC_DDEE_FF00;
        exp_data[2] = 64'h0000_0000_0000_1000;
        exp_data[3] = 64'h0000_0000_DEAD_BEEF;
        exp_data[4] = 64'h0000_0000_0000_0001;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s0 = cyc;
        wb1 = w1_n; rb1 = r1_n; cb1 = c1_n;
        wb3 = w3_n; rb3 = r3_n; cb3 = c3_n;
    endtask

    task automatic wait_complete(input bit use3, input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (use3 ? (c3_n > cb3) : (c1_n > cb1)) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (!d1_busy && !d3_busy && !d1_complete && !d3_complete) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; set_cfg_a();
        poll_interval = 16'd0; max_polls = 16'd0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({d1_wr_en, d1_wr_addr, d1_wr_data, d1_rd_en, d1_rd_addr, d1_busy, d1_complete,
             d1_err_mm, d1_err_to, d1_poll_count} !== 167'd0) begin
            errors++; $display("FAIL reset_outputs_l1: some output nonzero, busy=%b wr_en=%b rd_en=%b", d1_busy, d1_wr_en, d1_rd_en);
        end
        checks++;
        if ({d3_wr_en, d3_rd_en, d3_busy, d3_complete, d3_err_mm, d3_err_to, d3_poll_count} !== 22'd0) begin
            errors++; $display("FAIL reset_outputs_l3: some output nonzero, busy=%b", d3_busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_nominal();
        set_cfg_a(); poll_interval = 16'd4; max_polls = 16'd0; done_at = 3; corrupt = 1'b0;
        pulse_start();
        wait_complete(1'b0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nominal_complete: got none, required a pulse"); end
        checks++;
        if (w1_n - wb1 !== 5) begin errors++; $display("FAIL nominal_wr_count: got %0d required 5", w1_n - wb1); end
        for (int k = 0; k < 5; k++) begin
            logic [15:0] ea;
            int ec;
            ea = (k < 4) ? 16'h0052 + 16'(2 * k) : 16'h0050;
            ec = (k < 4) ? s0 + k : s0 + 12;
            checks++;
            if (w1_addr[wb1 + k] !== ea || w1_data[wb1 + k] !== exp_data[k] || w1_cyc[wb1 + k] !== ec) begin
                errors++;
                $display("FAIL nominal_write%0d: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                         k, w1_addr[wb1 + k], w1_data[wb1 + k], w1_cyc[wb1 + k] - s0, ea, exp_data[k], ec - s0);
            end
        end
        checks++;
        if (r1_n - rb1 !== 7) begin errors++; $display("FAIL nominal_rd_count: got %0d required 7", r1_n - rb1); end
        for (int k = 0; k < 7; k++) begin
            logic [15:0] ea;
            int ec;
            ea = (k < 4) ? 16'h0052 + 16'(2 * k) : 16'h0060;
            ec = (k < 4) ? s0 + 4 + 2 * k : s0 + 13 + 6 * (k - 4);
            checks++;
            if (r1_addr[rb1 + k] !== ea || r1_cyc[rb1 + k] !== ec) begin
                errors++;
                $display("FAIL nominal_read%0d: got addr=%h cyc=%0d required addr=%h cyc=%0d",
                         k, r1_addr[rb1 + k], r1_cyc[rb1 + k] - s0, ea, ec - s0);
            end
        end
        checks++;
        if (c1_cyc[cb1] !== s0 + 27 || c1_busy[cb1] !== 1'b0 || c1_pbusy[cb1] !== 1'b1) begin
            errors++;
            $display("FAIL nominal_complete_timing: got cyc=%0d busy=%b prev_busy=%b required cyc=27 busy=0 prev_busy=1",
                     c1_cyc[cb1] - s0, c1_busy[cb1], c1_pbusy[cb1]);
        end
        checks++;
        if ({d1_poll_count, d1_err_mm, d1_err_to} !== {16'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL nominal_status: got poll_count=%0d mm=%b to=%b required 3 0 0", d1_poll_count, d1_err_mm, d1_err_to);
        end
        wait_idle(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nominal_idle: got busy, required idle"); end
    endtask

    task automatic test_mismatch();
        set_cfg_a(); poll_interval = 16'd4; max_polls = 16'd0; done_at = 3; corrupt = 1'b1;
        pulse_start();
        wait_complete(1'b0, 100, ok);
        checks++;
        if (!ok || c1_cyc[cb1] !== s0 + 10) begin
            errors++; $display("FAIL mismatch_complete: got ok=%b cyc=%0d required cyc=10", ok, c1_cyc[cb1] - s0);
        end
        checks++;
        if ({d1_err_mm, d1_err_to} !== 2'b10) begin
            errors++; $display("FAIL mismatch_flags: got mm=%b to=%b required 1 0", d1_err_mm, d1_err_to);
        end
        checks++;
        if (w1_n - wb1 !== 4 || w1_addr[wb1 + 3] !== 16'h0058) begin
            errors++; $display("FAIL mismatch_writes: got %0d writes last=%h required 4 ending at 0058", w1_n - wb1, w1_addr[wb1 + 3]);
        end
        checks++;
        if (r1_n - rb1 !== 3 || r1_addr[rb1 + 2] !== 16'h0056) begin
            errors++; $display("FAIL mismatch_reads: got %0d reads last=%h required 3 ending at 0056", r1_n - rb1, r1_addr[rb1 + 2]);
        end
        wait_idle(300, ok);
        corrupt = 1'b0;
    endtask

    task automatic test_timeout();
        int np;
        set_cfg_a(); poll_interval = 16'd1; max_polls = 16'd5; done_at = 0;
        pulse_start();
        wait_complete(1'b0, 200, ok);
        np = 0;
        for (int k = rb1; k < r1_n; k++) if (r1_addr[k] == 16'h0060) np++;
        checks++;
        if (np !== 5) begin errors++; $display("FAIL timeout_polls: got %0d done reads required 5", np); end
        checks++;
        if ({d1_err_to, d1_err_mm, d1_poll_count} !== {1'b1, 1'b0, 16'd5}) begin
            errors++; $display("FAIL timeout_flags: got to=%b mm=%b count=%0d required 1 0 5", d1_err_to, d1_err_mm, d1_poll_count);
        end
        checks++;
        if (!ok || c1_cyc[cb1] !== s0 + 27) begin
            errors++; $display("FAIL timeout_complete: got ok=%b cyc=%0d required cyc=27", ok, c1_cyc[cb1] - s0);
        end
        wait_idle(400, ok);
        max_polls = 16'd0;
    endtask

    task automatic test_latency();
        set_cfg_a(); poll_interval = 16'd0; max_polls = 16'd0; done_at = 3;
        pulse_start();
        wait_complete(1'b1, 200, ok);
        checks++;
        if (!ok || c3_cyc[cb3] !== s0 + 33) begin
            errors++; $display("FAIL latency_complete: got ok=%b cyc=%0d required cyc=33", ok, c3_cyc[cb3] - s0);
        end
        checks++;
        if (r3_n - rb3 !== 7) begin errors++; $display("FAIL latency_rd_count: got %0d required 7", r3_n - rb3); end
        for (int k = 0; k < 7; k++) begin
            int ec;
            ec = (k < 4) ? s0 + 4 + 4 * k : s0 + 21 + 4 * (k - 4);
            checks++;
            if (r3_cyc[rb3 + k] !== ec) begin
                errors++; $display("FAIL latency_read%0d: got cyc=%0d required cyc=%0d", k, r3_cyc[rb3 + k] - s0, ec - s0);
            end
        end
        checks++;
        if (w3_n - wb3 !== 5 || w3_addr[wb3 + 4] !== 16'h0050 || w3_cyc[wb3 + 4] !== s0 + 20) begin
            errors++; $display("FAIL latency_go: got addr=%h cyc=%0d required 0050 at cyc=20", w3_addr[wb3 + 4], w3_cyc[wb3 + 4] - s0);
        end
        checks++;
        if ({d3_poll_count, d3_err_mm, d3_err_to} !== {16'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL latency_status: got count=%0d mm=%b to=%b required 3 0 0", d3_poll_count, d3_err_mm, d3_err_to);
        end
        wait_idle(300, ok);
    endtask

    task automatic test_back_to_back();
        set_cfg_a(); poll_interval = 16'd2; max_polls = 16'd0; done_at = 2;
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        cfg_rd_addr = 64'h0BAD_0BAD_0BAD_0BAD; cfg_wr_addr = 64'h0; cfg_num_samples = 32'h7;
        cfg_collect_cycles = 32'h1; poll_interval = 16'd0; max_polls = 16'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_complete(1'b0, 100, ok);
        checks++;
        if (!ok || c1_cyc[cb1] !== s0 + 19) begin
            errors++; $display("FAIL b2b_complete: got ok=%b cyc=%0d required cyc=19", ok, c1_cyc[cb1] - s0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (w1_data[wb1 + k] !== exp_data[k]) begin
                errors++; $display("FAIL b2b_write%0d: got data=%h required %h", k, w1_data[wb1 + k], exp_data[k]);
            end
        end
        checks++;
        if ({d1_err_mm, d1_err_to, d1_poll_count} !== {1'b0, 1'b0, 16'd2}) begin
            errors++; $display("FAIL b2b_status: got mm=%b to=%b count=%0d required 0 0 2", d1_err_mm, d1_err_to, d1_poll_count);
        end
        wait_idle(300, ok);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (c1_n - cb1 !== 1 || w1_n - wb1 !== 5) begin
            errors++; $display("FAIL b2b_single_run: got completes=%0d writes=%0d required 1 and 5", c1_n - cb1, w1_n - wb1);
        end
    endtask

    task automatic test_reset_midrun();
        int wsnap, rsnap;
        set_cfg_a(); poll_interval = 16'd10; max_polls = 16'd0; done_at = 0;
        pulse_start();
        repeat (18) @(posedge clk);
        #2;
        checks++;
        if (d1_busy !== 1'b1 || d1_poll_count !== 16'd1) begin
            errors++; $display("FAIL rst_precondition: got busy=%b count=%0d required 1 1", d1_busy, d1_poll_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({d1_wr_en, d1_wr_addr, d1_wr_data, d1_rd_en, d1_rd_addr, d1_busy, d1_complete,
             d1_err_mm, d1_err_to, d1_poll_count} !== 167'd0) begin
            errors++; $display("FAIL rst_immediate: got busy=%b count=%0d required all 0", d1_busy, d1_poll_count);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wsnap = w1_n + w3_n; rsnap = r1_n + r3_n;
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (w1_n + w3_n !== wsnap || r1_n + r3_n !== rsnap || d1_busy !== 1'b0 || d3_busy !== 1'b0) begin
            errors++; $display("FAIL rst_quiet: got %0d new strobes busy=%b required 0 and 0", w1_n + w3_n + r1_n + r3_n - wsnap - rsnap, d1_busy);
        end
        poll_interval = 16'd0; done_at = 1;
        pulse_start();
        wait_complete(1'b0, 100, ok);
        checks++;
        if (!ok || c1_cyc[cb1] !== s0 + 15 || d1_poll_count !== 16'd1) begin
            errors++; $display("FAIL rst_recovery: got ok=%b cyc=%0d count=%0d required cyc=15 count=1", ok, c1_cyc[cb1] - s0, d1_poll_count);
        end
        wait_idle(300, ok);
    endtask

    task automatic test_bus_rules();
        checks++;
        if (stray1 + ovl1 !== 0) begin errors++; $display("FAIL bus_rules_l1: got stray=%0d overlap=%0d required 0", stray1, ovl1); end
        checks++;
        if (stray3 + ovl3 !== 0) begin errors++; $display("FAIL bus_rules_l3: got stray=%0d overlap=%0d required 0", stray3, ovl3); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mismatch();
        test_timeout();
        test_latency();
        test_back_to_back();
        test_reset_midrun();
        test_bus_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
